// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the fetch/decode/execute pipeline sequencer.
// Holds the sequencer state encoding and the default register-address width.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pipe_state_t;

  localparam int REG_AW_DEF = 3;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detector: a load in execute whose rd feeds a decode source.
// Ports: rs_a_i/rs_b_i + uses_a_i/uses_b_i (decode), is_load_i/rd_i/rd_we_i (execute), load_use_o.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] rs_a_i,
  input  logic [REG_AW-1:0] rs_b_i,
  input  logic              uses_a_i,
  input  logic              uses_b_i,
  input  logic              is_load_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              rd_we_i,
  output logic              load_use_o
);

  logic hit_a;
  logic hit_b;

  assign hit_a = uses_a_i & (rs_a_i == rd_i);
  assign hit_b = uses_b_i & (rs_b_i == rd_i);

  assign load_use_o = is_load_i & rd_we_i & (hit_a | hit_b);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stage enables, load-use bubbles, mem freeze, branch flush, halt.
// Ports: clk, rst_n, stall/branch/halt inputs -> fetch_en/decode_en/exec_en/exec_bubble/pc_load/halted;
// stall_cnt/flush_cnt exist only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int FILL_CYCLES = 2
`ifdef PIPE_CTRL_PERF_EN
  ,
  parameter int PERF_W      = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_busy,
  input  logic [REG_AW-1:0] dec_rs_a,
  input  logic [REG_AW-1:0] dec_rs_b,
  input  logic              dec_uses_a,
  input  logic              dec_uses_b,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_rd_we,
  input  logic              branch_taken,
  input  logic              halt_req,
  input  logic              resume,
  output logic              fetch_en,
  output logic              decode_en,
  output logic              exec_en,
  output logic              exec_bubble,
  output logic              pc_load,
  output logic              halted
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);

  localparam int CW = $clog2(FILL_CYCLES + 1);
  localparam logic [CW-1:0] FC  = CW'(FILL_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);

  pipe_state_t   state_q, state_d;
  logic [CW-1:0] fill_q, fill_d;
  logic          load_use;

  hazard_detect #(
    .REG_AW(REG_AW)
  ) u_hz (
    .rs_a_i    (dec_rs_a),
    .rs_b_i    (dec_rs_b),
    .uses_a_i  (dec_uses_a),
    .uses_b_i  (dec_uses_b),
    .is_load_i (ex_is_load),
    .rd_i      (ex_rd),
    .rd_we_i   (ex_rd_we),
    .load_use_o(load_use)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      fill_q  <= FC;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    unique case (state_q)
      FILL: begin
        if (!mem_busy) begin
          fill_d = fill_q - ONE;
          if (fill_q <= ONE) state_d = RUN;
        end
      end
      RUN: begin
        if (mem_busy) begin
          state_d = RUN;
        end else if (branch_taken) begin
          // The branch cycle itself is the first bubble.
          if (FILL_CYCLES > 1) begin
            state_d = FILL;
            fill_d  = FC - ONE;
          end
        end else if (halt_req) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        if (resume) begin
          state_d = FILL;
          fill_d  = ONE;
        end
      end
      default: begin
        state_d = FILL;
        fill_d  = FC;
      end
    endcase
  end

  // Outputs are gated by rst_n so they drop the moment reset asserts.
  always_comb begin
    fetch_en    = 1'b0;
    decode_en   = 1'b0;
    exec_en     = 1'b0;
    exec_bubble = 1'b0;
    pc_load     = 1'b0;
    halted      = 1'b0;
    if (!rst_n) begin
      exec_bubble = 1'b1;
    end else begin
      unique case (state_q)
        FILL: begin
          if (!mem_busy) begin
            fetch_en    = 1'b1;
            decode_en   = 1'b1;
            exec_en     = 1'b1;
            exec_bubble = 1'b1;
          end
        end
        RUN: begin
          if (mem_busy) begin
            exec_bubble = 1'b0;
          end else if (branch_taken) begin
            pc_load     = 1'b1;
            fetch_en    = 1'b1;
            decode_en   = 1'b1;
            exec_en     = 1'b1;
            exec_bubble = 1'b1;
          end else if (halt_req) begin
            exec_bubble = 1'b0;
          end else if (load_use) begin
            exec_en     = 1'b1;
            exec_bubble = 1'b1;
          end else begin
            fetch_en    = 1'b1;
            decode_en   = 1'b1;
            exec_en     = 1'b1;
          end
        end
        HALTED: begin
          halted = 1'b1;
        end
        default: begin
          exec_bubble = 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic              run_cyc;
  logic              stall_ev;
  logic              flush_ev;
  logic [PERF_W-1:0] stall_q;
  logic [PERF_W-1:0] flush_q;

  assign run_cyc  = (state_q == RUN);
  assign stall_ev = run_cyc &
                    (mem_busy | (~branch_taken & ~halt_req & load_use));
  assign flush_ev = run_cyc & ~mem_busy & branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_ev && !(&stall_q)) stall_q <= stall_q + 1'b1;
      if (flush_ev && !(&flush_q)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`endif

endmodule
